// File: rtl/csa_resolver_if.sv
// Operand/result handshake bundle for csa_resolver; slave = resolver side, master = driver side.
// ovf is carried only when CSA_RESOLVE_OVF_EN is defined.
interface csa_resolver_if #(parameter int WIDTH = 16);
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] sum_vec;
    logic [WIDTH-1:0] carry_vec;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH+1:0] result;
`ifdef CSA_RESOLVE_OVF_EN
    logic             ovf;
`endif

    modport slave (
        input  s_valid, sum_vec, carry_vec, m_ready,
`ifdef CSA_RESOLVE_OVF_EN
        output ovf,
`endif
        output s_ready, m_valid, result
    );

    modport master (
        output s_valid, sum_vec, carry_vec, m_ready,
`ifdef CSA_RESOLVE_OVF_EN
        input  ovf,
`endif
        input  s_ready, m_valid, result
    );
endinterface

// File: rtl/csa_resolver.sv
// Purpose: resolves a carry-save pair (sum + 2*carry) to binary, CHUNK bits per cycle; optional ovf via CSA_RESOLVE_OVF_EN.
// Latency: m_valid rises WIDTH/CHUNK cycles after the accepting edge.
// Backpressure: one operation in flight; s_ready stays low until the result is taken with m_ready.
module csa_resolver #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    csa_resolver_if.slave bus
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH:0]   b_reg;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [WIDTH+1:0] result_q;
    logic             s_ready_q;
    logic             m_valid_q;
`ifdef CSA_RESOLVE_OVF_EN
    logic             ovf_q;
`endif

    logic [CHUNK-1:0] a_ch;
    logic [CHUNK-1:0] b_ch;
    logic [CHUNK-1:0] ch_sum;
    logic             ch_cout;
    logic             last;
    int               base;

    always_comb begin
        base = int'(idx) * CHUNK;
        a_ch = a_reg[base +: CHUNK];
        b_ch = b_reg[base +: CHUNK];
        {ch_cout, ch_sum} = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry};
        last = (idx == IW'(NCH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            idx       <= '0;
            carry     <= 1'b0;
            result_q  <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
`ifdef CSA_RESOLVE_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    s_ready_q <= 1'b1;
                    m_valid_q <= 1'b0;
                    // s_ready_q is low on the first cycle out of reset, so nothing is taken then
                    if (bus.s_valid && s_ready_q) begin
                        a_reg     <= bus.sum_vec;
                        b_reg     <= {bus.carry_vec, 1'b0};
                        idx       <= '0;
                        carry     <= 1'b0;
                        s_ready_q <= 1'b0;
                        state     <= ADD;
                    end
                end
                ADD: begin
                    result_q[base +: CHUNK] <= ch_sum;
                    carry                   <= ch_cout;
                    idx                     <= idx + IW'(1);
                    if (last) begin
                        // top two bits: the carry bit shifted past WIDTH plus the last chunk carry
                        result_q[WIDTH+1:WIDTH] <= {1'b0, b_reg[WIDTH]} + {1'b0, ch_cout};
`ifdef CSA_RESOLVE_OVF_EN
                        ovf_q                   <= b_reg[WIDTH] | ch_cout;
`endif
                        idx                     <= '0;
                        m_valid_q               <= 1'b1;
                        state                   <= DONE;
                    end
                end
                DONE: begin
                    if (bus.m_ready) begin
                        m_valid_q <= 1'b0;
                        s_ready_q <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.s_ready = s_ready_q;
    assign bus.m_valid = m_valid_q;
    assign bus.result  = result_q;
`ifdef CSA_RESOLVE_OVF_EN
    assign bus.ovf     = ovf_q;
`endif
endmodule

// File: tb/tb_csa_resolver.sv
// Scoreboard bench for csa_resolver: directed corner operands, backpressure hold, mid-operation reset, then random traffic.
module tb_csa_resolver;
    localparam int W   = 16;
    localparam int C   = 4;
    localparam int LAT = W / C;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    csa_resolver_if #(.WIDTH(W)) bus();

    csa_resolver #(.WIDTH(W), .CHUNK(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [W+1:0] res;
        logic         ovf;
        int           cyc;
    } exp_t;

    exp_t         sbq[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    bit           force_lo = 1'b0;
    bit           force_hi = 1'b0;
    bit           holding = 1'b0;
    bit           post_xfer = 1'b0;
    logic [W+1:0] held_res;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, req, cyc);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        bus.m_ready = force_lo ? 1'b0 : (force_hi ? 1'b1 : ($urandom_range(0, 3) != 0));
    end

    // monitor: samples mid-cycle, when inputs driven at posedge+1 are settled
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            holding   = 1'b0;
            post_xfer = 1'b0;
        end else begin
            if (post_xfer) begin
                chk("idle_after_xfer", 32'({bus.s_ready, bus.m_valid}), 32'h2);
                post_xfer = 1'b0;
            end
            if (bus.m_valid) begin
                chk("s_ready_low_in_done", 32'(bus.s_ready), 32'h0);
                if (!holding) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_m_valid: m_valid=1 with no operation outstanding at cycle %0d", cyc);
                    end else begin
                        chk("latency", 32'(cyc), 32'(sbq[0].cyc));
                        held_res = bus.result;
                        holding  = 1'b1;
                    end
                end else begin
                    chk("result_stable", 32'(bus.result), 32'(held_res));
                end
                if (bus.m_ready && holding) begin
                    e = sbq.pop_front();
                    chk("result", 32'(bus.result), 32'(e.res));
`ifdef CSA_RESOLVE_OVF_EN
                    chk("ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
                    holding   = 1'b0;
                    post_xfer = 1'b1;
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] sv, input logic [W-1:0] cv, input bit track);
        exp_t e;
        int   n;
        bus.sum_vec   = sv;
        bus.carry_vec = cv;
        bus.s_valid   = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.s_ready) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: s_ready=0 for 200 cycles, required 1");
                bus.s_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        if (track) begin
            e.res = (W+2)'(sv) + ((W+2)'(cv) * 2);
            e.ovf = (e.res >= (W+2)'(1 << W));
            e.cyc = cyc + 1 + LAT;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.s_valid   = 1'b0;
        bus.sum_vec   = W'($urandom);
        bus.carry_vec = W'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        logic [W-1:0] sv;
        logic [W-1:0] cv;
        int           n;
        bus.s_valid   = 1'b0;
        bus.sum_vec   = '0;
        bus.carry_vec = '0;
        #2;
        chk("reset_s_ready", 32'(bus.s_ready), 32'h0);
        chk("reset_m_valid", 32'(bus.m_valid), 32'h0);
        chk("reset_result", 32'(bus.result), 32'h0);
`ifdef CSA_RESOLVE_OVF_EN
        chk("reset_ovf", 32'(bus.ovf), 32'h0);
`endif
        #20 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("s_ready_after_reset", 32'(bus.s_ready), 32'h1);

        force_hi = 1'b1;
        send(16'h1234, 16'h0000, 1'b1);
        send(16'hFFFF, 16'hFFFF, 1'b1);
        send(16'h00FF, 16'h0080, 1'b1);
        drain();

        // downstream stalls for 5 cycles with the result held
        @(negedge clk);
        force_hi = 1'b0;
        force_lo = 1'b1;
        @(posedge clk);
        #1;
        send(16'hBEEF, 16'h7FFF, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.m_valid && n < 20);
        chk("stall_m_valid_seen", 32'(bus.m_valid), 32'h1);
        repeat (5) @(negedge clk);
        chk("stall_still_valid", 32'(bus.m_valid), 32'h1);
        force_lo = 1'b0;
        force_hi = 1'b1;
        @(posedge clk);
        #1;
        drain();

        // reset in the second ADD cycle discards the operation
        send(16'hABCD, 16'h1357, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        chk("midreset_m_valid", 32'(bus.m_valid), 32'h0);
        chk("midreset_result", 32'(bus.result), 32'h0);
        chk("midreset_s_ready", 32'(bus.s_ready), 32'h0);
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("postreset_s_ready", 32'(bus.s_ready), 32'h1);
        chk("postreset_result", 32'(bus.result), 32'h0);
        send(16'hABCD, 16'h1357, 1'b1);
        drain();

        force_hi = 1'b0;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0: begin sv = 16'hFFFF; cv = 16'hFFFF; end
                1: begin sv = W'($urandom); cv = 16'h0000; end
                2: begin sv = 16'h0000; cv = W'($urandom); end
                default: begin sv = W'($urandom); cv = W'($urandom); end
            endcase
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send(sv, cv, 1'b1);
        end
        force_hi = 1'b1;
        drain();
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
